// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and FSM encoding for the BCD/seven-segment display path
package seg7_pkg;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [13:0] MAX_DISPLAY = 14'd9999;
  localparam int NUM_DIGITS = 4;
  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_e;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble corrector, adds 3 when the digit is 5 or more
module bcd_add3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);
  assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;
endmodule

// File: rtl/bin2bcd_encoder.sv
// bin2bcd_encoder: iterative shift-add-3 binary to 4-digit BCD with blanking and overflow
module bin2bcd_encoder
  import seg7_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [3:0]       dig1_o,
  output logic [3:0]       dig2_o,
  output logic [3:0]       dig3_o,
  output logic [3:0]       dig4_o
);
  localparam int CW = $clog2(BIN_W + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d, bcd_adj, bcd_sh, dig_q, dig_d, dig_fmt;
  logic pend_q, pend_d, ovf_q, ovf_d, ovf_fin, z4, z3, z2;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.in_i(bcd_q[4*i+:4]), .out_o(bcd_adj[4*i+:4]));
  end
  assign bcd_sh = {bcd_adj[14:0], bin_q[BIN_W-1]};
  // a bit spilling past the thousands digit also means the value exceeds 9999
  assign ovf_fin = pend_q | bcd_adj[15];
  always_comb begin
    z4 = bcd_sh[15:12] == 4'd0;
    z3 = z4 && bcd_sh[11:8] == 4'd0;
    z2 = z3 && bcd_sh[7:4] == 4'd0;
    dig_fmt = ovf_fin ? {NUM_DIGITS{BCD_BLANK}} :
              {(LZ_BLANK && z4) ? BCD_BLANK : bcd_sh[15:12],
               (LZ_BLANK && z3) ? BCD_BLANK : bcd_sh[11:8],
               (LZ_BLANK && z2) ? BCD_BLANK : bcd_sh[7:4],
               bcd_sh[3:0]};
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = CONV;
        cnt_d   = '0;
        bin_d   = bin_i;
        bcd_d   = '0;
        pend_d  = 14'(bin_i) > MAX_DISPLAY;
      end
      CONV: begin
        cnt_d  = cnt_q + 1'b1;
        bin_d  = bin_q << 1;
        bcd_d  = bcd_sh;
        pend_d = ovf_fin;
        if (cnt_q == CW'(BIN_W - 1)) begin
          state_d = FINISH;
          dig_d   = dig_fmt;
          ovf_d   = ovf_fin;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= {NUM_DIGITS{BCD_BLANK}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == FINISH;
  assign ovf_o  = ovf_q;
  assign {dig4_o, dig3_o, dig2_o, dig1_o} = dig_q;
endmodule

// File: tb/tb_bin2bcd_encoder.sv
// tb_bin2bcd_encoder: directed checks of latency, digits, blanking, overflow, handshake and reset
module tb_bin2bcd_encoder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [13:0] bin = '0;
  logic busy0, done0, ovf0, busy1, done1, ovf1;
  logic [3:0] a1, a2, a3, a4, b1, b2, b3, b4;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  bin2bcd_encoder #(.BIN_W(14), .LZ_BLANK(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin), .busy_o(busy0), .done_o(done0),
    .ovf_o(ovf0), .dig1_o(a1), .dig2_o(a2), .dig3_o(a3), .dig4_o(a4));
  bin2bcd_encoder #(.BIN_W(14), .LZ_BLANK(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin), .busy_o(busy1), .done_o(done1),
    .ovf_o(ovf1), .dig1_o(b1), .dig2_o(b2), .dig3_o(b3), .dig4_o(b4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input int v, input logic [15:0] e0, input logic [15:0] e1, input logic eovf);
    int dk;
    dk = 0;
    start = 1'b1;
    bin = 14'(v);
    for (int k = 1; k <= 40 && dk == 0; k++) begin
      step();
      start = 1'b0;
      bin = ~bin;
      chk("busy_during_conv", {busy0, busy1}, 2'b11);
      if (done0) dk = k;
    end
    chk("done_cycle", dk, 15);
    chk("done_lz1", done1, 1);
    chk("digits_lz0", {a4, a3, a2, a1}, e0);
    chk("digits_lz1", {b4, b3, b2, b1}, e1);
    chk("ovf", {ovf0, ovf1}, {eovf, eovf});
    step();
    chk("done_single_pulse", {done0, done1}, 2'b00);
    chk("busy_idle", {busy0, busy1}, 2'b00);
  endtask

  initial begin
    int nd;
    int ok_cyc;
    repeat (2) step();
    chk("rst_busy", {busy0, busy1}, 2'b00);
    chk("rst_done", {done0, done1}, 2'b00);
    chk("rst_ovf", {ovf0, ovf1}, 2'b00);
    chk("rst_dig_lz0", {a4, a3, a2, a1}, 16'hFFFF);
    chk("rst_dig_lz1", {b4, b3, b2, b1}, 16'hFFFF);
    rst = 1'b0;

    convert(1234, 16'h1234, 16'h1234, 1'b0);
    convert(7, 16'h0007, 16'hFFF7, 1'b0);
    convert(0, 16'h0000, 16'hFFF0, 1'b0);
    convert(9999, 16'h9999, 16'h9999, 1'b0);
    convert(1005, 16'h1005, 16'h1005, 1'b0);
    convert(10000, 16'hFFFF, 16'hFFFF, 1'b1);
    step();
    chk("ovf_held", {ovf0, ovf1}, 2'b11);
    convert(16383, 16'hFFFF, 16'hFFFF, 1'b1);
    convert(42, 16'h0042, 16'hFF42, 1'b0);

    // start held high, bin changing every cycle: accepts at cycles 0, 16, 32
    nd = 0;
    ok_cyc = 1;
    start = 1'b1;
    for (int c = 0; c < 47; c++) begin
      bin = 14'(100 + c);
      step();
      if (done0 || done1) begin
        nd++;
        if (c + 1 != 16 * nd - 1) ok_cyc = 0;
        chk("hs_lz0", {a4, a3, a2, a1}, {4'h0, 12'(((100 + 16 * (nd - 1)) / 100) << 8 |
              (((100 + 16 * (nd - 1)) / 10) % 10) << 4 | ((100 + 16 * (nd - 1)) % 10))});
        chk("hs_lz1", {b4, b3, b2, b1}, {4'hF, 12'(((100 + 16 * (nd - 1)) / 100) << 8 |
              (((100 + 16 * (nd - 1)) / 10) % 10) << 4 | ((100 + 16 * (nd - 1)) % 10))});
      end
    end
    start = 1'b0;
    chk("hs_done_count", nd, 3);
    chk("hs_done_cycles", ok_cyc, 1);
    step();

    // reset during conversion aborts with no done and blank digits
    nd = 0;
    start = 1'b1;
    bin = 14'd5678;
    for (int c = 1; c <= 7; c++) begin
      step();
      start = 1'b0;
      if (done0 || done1) nd++;
    end
    rst = 1'b1;
    step();
    chk("abort_busy", {busy0, busy1}, 2'b00);
    chk("abort_dig_lz0", {a4, a3, a2, a1}, 16'hFFFF);
    chk("abort_dig_lz1", {b4, b3, b2, b1}, 16'hFFFF);
    chk("abort_ovf", {ovf0, ovf1}, 2'b00);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done0 || done1) nd++;
    end
    chk("abort_no_done", nd, 0);
    convert(5678, 16'h5678, 16'h5678, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bin2bcd_encoder.md
Name: bin2bcd_encoder

Overview:
- Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble). It sits upstream of the 4-digit seven-segment decoder.
- Converts a binary count (score, timer) into four BCD digits plus blank codes.
- Start/busy/done handshake; results are registered and held, so the display never shows intermediate values.

Parameters:
- BIN_W, 14, width of binary input. Legal range 4..14; 14 bits covers 9999.
- LZ_BLANK, 1, when 1, leading zero digits are output as 4'hF (blank code); the units digit is never blanked.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request conversion; accepted only when busy_o=0
- bin_i  input  BIN_W  binary value; sampled in the accepting cycle only
- busy_o  output  1  conversion in progress
- done_o  output  1  one-cycle pulse; digit outputs updated in this cycle
- ovf_o  output  1  last accepted value exceeded 9999; held until next done_o
- dig1_o  output  4  units digit (BCD or 4'hF)
- dig2_o  output  4  tens digit
- dig3_o  output  4  hundreds digit
- dig4_o  output  4  thousands digit

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: busy_o=0, done_o=0, ovf_o=0, dig1_o..dig4_o=4'hF (blank display). FSM goes to IDLE.
- FSM states:
  - IDLE: busy_o=0. If start_i=1, capture bin_i into the shift register, clear the 16-bit BCD accumulator and the iteration counter, go to CONV.
  - CONV: busy_o=1. On each edge, every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1. After the BIN_W-th iteration, go to FINISH.
  - FINISH: busy_o=1, done_o=1. Output registers are loaded on the edge entering FINISH. Next state is IDLE.
- Latency: start_i high in cycle 0 gives busy_o high in cycles 1..BIN_W+1. done_o and new digits appear in cycle BIN_W+1 (cycle 15 at default). The earliest next accepted start is cycle BIN_W+2.
- start_i while busy_o=1 is ignored, not queued. bin_i changes during CONV have no effect.
- Overflow: if the captured value is >9999 (only possible when BIN_W=14 and value is 10000..16383), ovf_o=1 at done and all four digits=4'hF.
  - ovf_o clears at the next done_o with an in-range value.
- Leading-zero blanking (LZ_BLANK=1): digits more significant than the highest nonzero digit output 4'hF. A value of 0 gives dig1_o=0 and the others 4'hF. Blanking is applied when loading the output registers, not during iteration.
- Add-3 correction uses 4-bit nibble arithmetic. A nibble never exceeds 9 before correction, so no carry between nibbles is possible.
- Iteration counter width is clog2(BIN_W+1); the counter wraps only via reset/IDLE reload.
- Reset mid-CONV or in FINISH: abort immediately, no done_o, outputs go to their reset values.
- Digit outputs change only at a FINISH load or at reset; they are stable for the downstream combinational decoder.

Decomposition:
- Shared package seg7_pkg:
  - BCD_BLANK=4'hF
  - MAX_DISPLAY=14'd9999
  - NUM_DIGITS=4
  - FSM state encoding: IDLE, CONV, FINISH
- One natural sub-module: bcd_add3, a combinational 4-bit corrector (in>=5 ? in+3 : in), instantiated 4 times per iteration.

Test Plan:
- Reset check: assert rst_i for 2 cycles -> busy_o=0, done_o=0, ovf_o=0, all digits 4'hF.
- Nominal, LZ_BLANK=0: start with bin_i=1234 in cycle 0 -> done_o only in cycle 15; dig4..dig1=1,2,3,4; ovf_o=0; busy_o high cycles 1..15.
- Blanking and boundaries:
  - LZ_BLANK=1: bin_i=7 -> digits F,F,F,7.
  - bin_i=0 -> F,F,F,0.
  - bin_i=9999 -> 9,9,9,9.
  - bin_i=1005 -> 1,0,0,5 (embedded zeros not blanked).
- Overflow: bin_i=10000, then 16383 -> ovf_o=1, all digits F. A following conversion of 42 -> ovf_o=0, digits F,F,4,2.
- Handshake: start held high continuously with bin_i changing every cycle -> conversions accepted in cycles 0, 16, 32. Each result matches bin_i as sampled in that cycle; exactly one done_o per conversion.
- Reset mid-operation: start 5678, assert rst_i in cycle 7 -> no done_o, digits 4'hF. A following start 5678 -> 5,6,7,8 after 15 cycles.
